// File: rtl/sysp_timer_pkg.sv
// Shared register map, control/status bit positions and helpers for the timer peripheral.
package sysp_timer_pkg;

    // Register offsets within the slot (word aligned)
    localparam logic [7:0] TMR_CTRL = 8'h00;
    localparam logic [7:0] TMR_CNT  = 8'h04;
    localparam logic [7:0] TMR_TOP  = 8'h08;
    localparam logic [7:0] TMR_CMP  = 8'h0C;
    localparam logic [7:0] TMR_STAT = 8'h10;

    // CTRL / STAT bit positions
    localparam int TMR_EN_BIT      = 0;
    localparam int TMR_ONESHOT_BIT = 1;
    localparam int TMR_PWM_EN_BIT  = 2;
    localparam int TMR_IRQ_EN_BIT  = 3;
    localparam int TMR_PSC_LSB     = 16;
    localparam int TMR_OVF_BIT     = 0;
    localparam int TMR_CMPF_BIT    = 1;

    // Low nibble of CTRL; field order matches the bit positions above
    typedef struct packed {
        logic irq_en;
        logic pwm_en;
        logic oneshot;
        logic en;
    } tmr_ctrl_t;

    // Byte-lane merge of a write into an existing 32-bit register
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sysp_timer_psc.sv
// Prescaler: emits a one-cycle tick every (psc+1) enabled cycles.
module timer_psc #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [PSC_W-1:0] i_psc,
    output logic             o_tick
);

    logic [PSC_W-1:0] r_psc_cnt;
    logic             w_hit;

    assign w_hit  = (r_psc_cnt == i_psc);
    // A CTRL write restarts the prescale period, so it also swallows the tick
    assign o_tick = i_en & ~i_clr & w_hit;

    // Prescale counter: restart when disabled, on CTRL write, or at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc_cnt <= '0;
        end else if (!i_en || i_clr || w_hit) begin
            r_psc_cnt <= '0;
        end else begin
            r_psc_cnt <= r_psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/sysp_timer.sv
// Timer/PWM peripheral: register file, auto-reload counter, compare flag, PWM pin and level IRQ.
module sysp_timer
    import sysp_timer_pkg::*;
#(
    parameter int          PSC_W   = 16,
    parameter logic [31:0] RST_TOP = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic        pwm_o,
    output logic        irq_o
);

    tmr_ctrl_t        r_ctrl;
    logic [PSC_W-1:0] r_psc;
    logic [31:0]      r_cnt;
    logic [31:0]      r_top;
    logic [31:0]      r_cmp;
    logic             r_ovf;
    logic             r_cmpf;
    logic [31:0]      r_data;
    logic             r_pwm;

    logic        w_wr_ctrl, w_wr_cnt, w_wr_top, w_wr_cmp, w_wr_stat;
    logic [15:0] w_psc16;
    logic [15:0] w_psc_new;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_rd_val;
    logic        w_tick;
    logic        w_cnt_tick;
    logic        w_wrap;
    logic        w_set_ovf, w_set_cmpf;
    logic [1:0]  w_stat_clr;

    assign w_wr_ctrl = we_i && (waddr_i == TMR_CTRL);
    assign w_wr_cnt  = we_i && (waddr_i == TMR_CNT);
    assign w_wr_top  = we_i && (waddr_i == TMR_TOP);
    assign w_wr_cmp  = we_i && (waddr_i == TMR_CMP);
    assign w_wr_stat = we_i && (waddr_i == TMR_STAT);

    // Zero-extend the stored prescaler to the 16-bit CTRL field
    always_comb begin
        w_psc16            = '0;
        w_psc16[PSC_W-1:0] = r_psc;
    end

    assign w_ctrl_rd = {w_psc16, 12'h000, r_ctrl};
    assign w_psc_new = {sel_i[3] ? data_i[31:24] : w_psc16[15:8],
                        sel_i[2] ? data_i[23:16] : w_psc16[7:0]};

    timer_psc #(.PSC_W(PSC_W)) u_psc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_ctrl.en),
        .i_clr  (w_wr_ctrl),
        .i_psc  (r_psc),
        .o_tick (w_tick)
    );

    // A software CNT write in a tick cycle cancels that tick's counting and flags
    assign w_cnt_tick = w_tick & ~w_wr_cnt;
    assign w_wrap     = (r_cnt == r_top);
    assign w_set_ovf  = w_cnt_tick & w_wrap;
    assign w_set_cmpf = w_cnt_tick & (r_cnt == r_cmp);
    assign w_stat_clr = (w_wr_stat && sel_i[0]) ? data_i[1:0] : 2'b00;

    // CTRL: software write has priority over the one-shot auto-disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
            r_psc  <= '0;
        end else if (w_wr_ctrl) begin
            if (sel_i[0]) r_ctrl <= tmr_ctrl_t'(data_i[3:0]);
            r_psc <= w_psc_new[PSC_W-1:0];
        end else if (w_set_ovf && r_ctrl.oneshot) begin
            r_ctrl.en <= 1'b0;
        end
    end

    // Counter with auto-reload at TOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wr_cnt) begin
            r_cnt <= byte_merge(r_cnt, data_i, sel_i);
        end else if (w_tick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 32'd1;
        end
    end

    // TOP and CMP are plain byte-laned registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top <= RST_TOP;
            r_cmp <= '0;
        end else begin
            if (w_wr_top) r_top <= byte_merge(r_top, data_i, sel_i);
            if (w_wr_cmp) r_cmp <= byte_merge(r_cmp, data_i, sel_i);
        end
    end

    // Sticky status flags: hardware set beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_cmpf <= 1'b0;
        end else begin
            r_ovf  <= (r_ovf  & ~w_stat_clr[TMR_OVF_BIT])  | w_set_ovf;
            r_cmpf <= (r_cmpf & ~w_stat_clr[TMR_CMPF_BIT]) | w_set_cmpf;
        end
    end

    // Read mux; unmapped offsets read zero
    always_comb begin
        w_rd_val = '0;
        case (raddr_i)
            TMR_CTRL: w_rd_val = w_ctrl_rd;
            TMR_CNT:  w_rd_val = r_cnt;
            TMR_TOP:  w_rd_val = r_top;
            TMR_CMP:  w_rd_val = r_cmp;
            TMR_STAT: w_rd_val = {30'd0, r_cmpf, r_ovf};
            default:  w_rd_val = '0;
        endcase
    end

    // Registered read data, held between read strobes; samples pre-write state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (rd_i) begin
            r_data <= w_rd_val;
        end
    end

    // PWM output lags CNT by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= r_ctrl.pwm_en & (r_cnt < r_cmp);
        end
    end

    assign data_o = r_data;
    assign pwm_o  = r_pwm;
    assign irq_o  = r_ctrl.irq_en & (r_ovf | r_cmpf);

endmodule

// File: tb/tb_sysp_timer.sv
// Self-checking bench for sysp_timer: directed scenarios plus randomized runs
// checked against a closed-form tick/count model.
module tb_sysp_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0;
    logic [7:0]  raddr_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] data_o;
    logic        pwm_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] A_CTRL = 8'h00, A_CNT = 8'h04, A_TOP = 8'h08,
                           A_CMP = 8'h0C, A_STAT = 8'h10, A_NONE = 8'h14;

    sysp_timer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr_i (waddr_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .raddr_i (raddr_i),
        .rd_i    (rd_i),
        .data_o  (data_o),
        .pwm_o   (pwm_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        waddr_i = a; data_i = d; sel_i = s; we_i = 1'b1;
        @(posedge clk); #1;
        we_i = 1'b0; sel_i = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        raddr_i = a; rd_i = 1'b1;
        @(posedge clk); #1;
        rd_i = 1'b0;
        d = data_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Closed-form model: after k edges since EN was written, ticks = k/(psc+1)
    function automatic int m_cnt(int k, int psc, int top);
        return (k / (psc + 1)) % (top + 1);
    endfunction

    function automatic logic [31:0] m_stat(int k, int psc, int top, int cmp);
        int t;
        logic [31:0] s;
        t = k / (psc + 1);
        s = '0;
        s[0] = (t >= top + 1);
        s[1] = (cmp <= top) && (t >= cmp + 1);
        return s;
    endfunction

    initial begin
        logic [31:0] d;
        int hi;
        int psc, top, cmp, m;
        logic pe, ie;
        logic [31:0] st;

        // ---------- reset state ----------
        do_reset();
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_pwm_o", {31'd0, pwm_o}, 32'h0);
        chk("rst_irq_o", {31'd0, irq_o}, 32'h0);
        rd(A_TOP, d);  chk("rst_top", d, 32'hFFFF_FFFF);
        rd(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
        rd(A_CNT, d);  chk("rst_cnt", d, 32'h0);
        rd(A_STAT, d); chk("rst_stat", d, 32'h0);

        // ---------- unmapped offset, byte lanes, read-during-write ----------
        rd(A_TOP, d);
        wr(A_NONE, 32'hFFFF_FFFF, 4'hF);
        rd(A_NONE, d); chk("rd_unmapped", d, 32'h0);
        waddr_i = A_TOP; data_i = 32'h1234_5678; sel_i = 4'b0011; we_i = 1'b1;
        raddr_i = A_TOP; rd_i = 1'b1;
        @(posedge clk); #1;
        we_i = 1'b0; rd_i = 1'b0; sel_i = '0;
        chk("rd_prewrite", data_o, 32'hFFFF_FFFF);
        rd(A_TOP, d); chk("top_bytelane", d, 32'hFFFF_5678);
        wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        rd(A_CTRL, d); chk("ctrl_reserved", d, 32'hFFFF_0000);

        // ---------- 1: prescaled count, first wrap at 20th clock ----------
        do_reset();
        wr(A_CMP, 32'h0000_FFFF, 4'hF);
        wr(A_TOP, 32'd4, 4'hF);
        wr(A_CTRL, (32'd3 << 16) | 32'h1, 4'hF);
        idle(17);
        rd(A_CNT, d);  chk("t1_cnt_e17", d, 32'd4);
        rd(A_STAT, d); chk("t1_stat_e18", d, 32'h0);
        rd(A_STAT, d); chk("t1_stat_e19", d, 32'h0);
        rd(A_STAT, d); chk("t1_stat_e20", d, 32'h1);
        rd(A_CNT, d);  chk("t1_cnt_e21", d, 32'd0);

        // ---------- 2: PWM duty ----------
        do_reset();
        wr(A_TOP, 32'd9, 4'hF);
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        for (int j = 1; j <= 20; j++) begin
            idle(1);
            chk("t2_pwm_lag", {31'd0, pwm_o}, {31'd0, ((j - 1) % 10) < 3});
        end
        hi = 0;
        for (int j = 0; j < 10; j++) begin
            idle(1);
            if (pwm_o) hi++;
        end
        chk("t2_duty_3of10", hi, 3);
        wr(A_CMP, 32'd0, 4'hF);
        idle(1);
        hi = 0;
        for (int j = 0; j < 12; j++) begin
            idle(1);
            if (pwm_o) hi++;
        end
        chk("t2_cmp0_low", hi, 0);
        wr(A_CMP, 32'd10, 4'hF);
        idle(1);
        hi = 0;
        for (int j = 0; j < 12; j++) begin
            idle(1);
            if (pwm_o) hi++;
        end
        chk("t2_cmp10_high", hi, 12);

        // ---------- 3: one-shot, with and without IRQ_EN ----------
        for (int v = 0; v < 2; v++) begin
            do_reset();
            wr(A_TOP, 32'd2, 4'hF);
            wr(A_CTRL, 32'h3 | (32'(v) << 3), 4'hF);
            idle(10);
            rd(A_CTRL, d); chk("t3_ctrl_en_clr", d, 32'h2 | (32'(v) << 3));
            rd(A_CNT, d);  chk("t3_cnt", d, 32'd0);
            rd(A_STAT, d); chk("t3_stat", d, 32'h3);
            chk("t3_irq", {31'd0, irq_o}, 32'(v));
            idle(5);
            rd(A_CNT, d);  chk("t3_cnt_frozen", d, 32'd0);
        end

        // ---------- 4: W1C collides with OVF set ----------
        do_reset();
        wr(A_TOP, 32'd4, 4'hF);
        wr(A_CMP, 32'd7, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        idle(4);
        wr(A_STAT, 32'h1, 4'h1);
        rd(A_STAT, d); chk("t4_set_wins", d, 32'h1);
        chk("t4_irq_set", {31'd0, irq_o}, 32'h1);
        wr(A_STAT, 32'h3, 4'h1);
        rd(A_STAT, d); chk("t4_w1c", d, 32'h0);
        chk("t4_irq_clr", {31'd0, irq_o}, 32'h0);

        // ---------- 5: CNT byte write during a tick ----------
        do_reset();
        wr(A_TOP, 32'hAABB_CC02, 4'hF);
        wr(A_CMP, 32'hAABB_CC02, 4'hF);
        wr(A_CNT, 32'hAABB_CC00, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        idle(2);
        wr(A_CNT, 32'h0000_0055, 4'b0001);
        rd(A_CNT, d);  chk("t5_sw_wins", d, 32'hAABB_CC55);
        rd(A_CNT, d);  chk("t5_resume", d, 32'hAABB_CC56);
        rd(A_STAT, d); chk("t5_no_flags", d, 32'h0);

        // ---------- 6: async reset mid-count ----------
        do_reset();
        wr(A_TOP, 32'd100, 4'hF);
        wr(A_CMP, 32'd50, 4'hF);
        wr(A_CTRL, 32'hF, 4'hF);
        idle(10);
        rd(A_CNT, d); chk("t6_precnt", d, 32'd10);
        chk("t6_prepwm", {31'd0, pwm_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", data_o, 32'h0);
        chk("t6_rst_pwm", {31'd0, pwm_o}, 32'h0);
        chk("t6_rst_irq", {31'd0, irq_o}, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle(5);
        rd(A_CNT, d);  chk("t6_cnt", d, 32'h0);
        rd(A_CTRL, d); chk("t6_ctrl", d, 32'h0);
        rd(A_CMP, d);  chk("t6_cmp", d, 32'h0);
        rd(A_STAT, d); chk("t6_stat", d, 32'h0);
        rd(A_TOP, d);  chk("t6_top", d, 32'hFFFF_FFFF);

        // ---------- randomized runs vs. closed-form model ----------
        for (int it = 0; it < 24; it++) begin
            do_reset();
            psc = $urandom_range(0, 3);
            top = $urandom_range(0, 7);
            cmp = $urandom_range(0, 9);
            pe  = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            m   = $urandom_range(1, 40);
            wr(A_TOP, 32'(top), 4'hF);
            wr(A_CMP, 32'(cmp), 4'hF);
            wr(A_CTRL, (32'(psc) << 16) | (32'(ie) << 3) | (32'(pe) << 2) | 32'h1, 4'hF);
            for (int j = 1; j <= m; j++) begin
                idle(1);
                chk("rnd_pwm", {31'd0, pwm_o},
                    {31'd0, pe && (m_cnt(j - 1, psc, top) < cmp)});
            end
            st = m_stat(m, psc, top, cmp);
            chk("rnd_irq", {31'd0, irq_o}, {31'd0, ie && (st != 0)});
            rd(A_CNT, d);  chk("rnd_cnt", d, 32'(m_cnt(m, psc, top)));
            rd(A_STAT, d); chk("rnd_stat", d, m_stat(m + 1, psc, top, cmp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
